shift_reg_universal: RTL
========================

# shift_reg_universal

Parametrised universal shift register built from per-bit flop cells. It is the multi-bit, multi-mode successor to the single-bit reset flop used in the serial-in/parallel-out path. It supports hold, shift right, shift left and parallel load, and counts shifted bits so it can flag each completed serial-to-parallel word. It sits between a serial receive line and the parallel word consumer, and is reusable as a PISO for transmit.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  operation enable; 0 forces hold regardless of mode.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin  in  1  serial input bit.
- pin  in  WIDTH  parallel load data.
- pout  out  WIDTH  register contents q.
- sout_r  out  1  q[0], the serial output for shift right; combinational from q.
- sout_l  out  1  q[WIDTH-1], the serial output for shift left; combinational from q.
- word_valid  out  1  registered one-cycle pulse: WIDTH shifts have completed since the last load, reset or pulse.
- bit_cnt  out  CW  shifts accumulated in the current word, 0..WIDTH-1.

## Operation
- Reset asserted: q=0, bit_cnt=0, word_valid=0 immediately, without waiting for a clock edge. Reset overrides everything, including mid-word shifting.
- en=0 or mode=00: q and bit_cnt hold; word_valid=0 on the next edge.
- mode=01 (shift right): q ← {sin, q[WIDTH-1:1]}.
- mode=10 (shift left): q ← {q[WIDTH-2:0], sin}.
- mode=11 (parallel load): q ← pin; bit_cnt ← 0; word_valid ← 0. A load aborts any partial word.
- bit_cnt counting on any shift (01 or 10) with en=1:
  - bit_cnt==WIDTH-1: bit_cnt ← 0 and word_valid ← 1.
  - otherwise: bit_cnt ← bit_cnt+1 and word_valid ← 0.
- Direction changes mid-word are legal. The count includes shifts in both directions, and there is no direction-based reset of the count.
- Back-to-back words: continuous shifting gives word_valid every WIDTH cycles, with no gap cycles required.

## Timing
- Latency, serial to parallel: a bit presented on sin before edge N appears in q after edge N.
- word_valid is high in the cycle immediately after the WIDTH-th shift edge. In that cycle pout holds the complete word.
- If shifting continues, pout changes at the next edge. The consumer must capture pout during the word_valid cycle.
- sout_r and sout_l reflect q with zero added latency. For PISO use, the bit is sampled externally before each shift edge.
- Simultaneous reset and any other input: reset wins.
- Reset deassertion: operation resumes on the first rising edge at which rst=0.

## Structure
- Shared package shift_reg_pkg holds:
  - mode encoding constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - a typedef for the 2-bit mode.
- Sub-module usr_bit_cell, instantiated WIDTH times via generate:
  - inputs: clk, rst, en, mode, left neighbour bit, right neighbour bit, parallel bit;
  - contains a 4:1 next-state mux feeding an async-reset flop.
  - End cells receive sin in place of the missing neighbour.
- The top level holds the bit counter, the word_valid register and the serial-output taps.

## Test plan
All scenarios use WIDTH=8.
- Async reset: mid-word, with bit_cnt=5, pulse rst between clock edges → pout=0x00, bit_cnt=0, word_valid=0 before the next edge.
- Shift right: 8 shifts with sin sequence 1,0,1,1,0,0,1,0 → pout=0x4D after the 8th edge; word_valid=1 for exactly that one cycle.
- Shift left: same sin sequence → pout=0xB2 after the 8th edge; word_valid=1 for one cycle.
- Load then shift right: load 0xA5, then 3 shifts right with sin=0 → sout_r reads 1,0,1 before each edge; pout=0x14; bit_cnt=3; word_valid stays 0.
- Hold: en=0 with mode=01 for 4 cycles, or en=1 with mode=00 → pout and bit_cnt unchanged; word_valid=0.
- Load aborts word: 5 shifts, then load 0x3C → bit_cnt=0. word_valid first pulses only after 8 further shifts. 16 continuous shifts give exactly 2 pulses, 8 cycles apart.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/shift_reg_universal_bit_cell.sv
// One bit of the universal shift register: 4:1 next-state mux into an async-reset flop.
module usr_bit_cell
  import shift_reg_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_t mode,
  input  logic  left,
  input  logic  right,
  input  logic  par,
  output logic  q
);

  logic d;

  always_comb begin
    d = q;
    unique case (mode)
      MODE_HOLD: d = q;
      MODE_SHR:  d = left;
      MODE_SHL:  d = right;
      MODE_LOAD: d = par;
      default:   d = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= 1'b0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register (hold/shr/shl/load) with shift counter and word-complete pulse.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             word_valid,
  output logic [CW-1:0]    bit_cnt
);

  logic [WIDTH-1:0] q;
  // sin padded on both ends so every cell sees uniform left/right neighbours
  logic [WIDTH+1:0] ext;
  mode_t            mode_e;
  logic             shifting;

  assign mode_e   = mode_t'(mode);
  assign ext      = {sin, q, sin};
  assign shifting = en && (mode_e == MODE_SHR || mode_e == MODE_SHL);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode_e),
      .left  (ext[i+2]),
      .right (ext[i]),
      .par   (pin[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (shifting) begin
        if (bit_cnt == CW'(WIDTH - 1)) begin
          bit_cnt    <= '0;
          word_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (en && mode_e == MODE_LOAD) begin
        bit_cnt <= '0;
      end
    end
  end

  assign pout   = q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule
